// File: rtl/jram_loadable.sv
// Single-port CPU RAM with an address register (MAR), bus-style set/enable
// controls and a stream loader that fills memory from address 0.
module jram_loadable #(
  parameter int WIDTH     = 8,
  parameter int ADDR_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     bus_in,
  input  logic                 sa,
  input  logic                 s,
  input  logic                 e,
  output logic [WIDTH-1:0]     bus_out,
  input  logic                 ld_start,
  input  logic                 ld_valid,
  input  logic [WIDTH-1:0]     ld_data,
  input  logic                 ld_last,
  output logic                 ld_ready,
  output logic                 ld_busy,
  output logic                 ld_done,
  output logic [ADDR_BITS:0]   ld_count
);

  localparam int DEPTH = 2 ** ADDR_BITS;
  localparam int CW    = ADDR_BITS + 1;

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t                 state, state_next;
  logic [WIDTH-1:0]       mem [DEPTH];
  logic [ADDR_BITS-1:0]   mar;
  logic [ADDR_BITS-1:0]   ld_ptr;
  logic [ADDR_BITS:0]     count_q;
  logic                   accept;
  logic                   cpu_en;
  logic                   ptr_full;

  assign accept   = (state == LOAD) && ld_valid;
  assign cpu_en   = (state != LOAD);
  assign ptr_full = (ld_ptr == '1);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (ld_start) state_next = LOAD;
      LOAD:    if (accept && (ld_last || ptr_full)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      mar     <= '0;
      ld_ptr  <= '0;
      count_q <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && ld_start) begin
        ld_ptr  <= '0;
        count_q <= '0;
      end
      // Pointer may wrap after the final full-depth word; the FSM is already
      // leaving LOAD and the next start clears it before use.
      if (accept) begin
        ld_ptr  <= ld_ptr + ADDR_BITS'(1);
        count_q <= count_q + CW'(1);
      end
      if (cpu_en && sa) mar <= bus_in[ADDR_BITS-1:0];
    end
  end

  // Array has no reset: contents survive reset; writes uses the pre-edge MAR.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (accept)
        mem[ld_ptr] <= ld_data;
      else if (cpu_en && s)
        mem[mar] <= bus_in;
    end
  end

  assign ld_ready = (state == LOAD);
  assign ld_busy  = (state == LOAD);
  assign ld_done  = (state == DONE);
  assign ld_count = count_q;
  assign bus_out  = (e && state != LOAD) ? mem[mar] : '0;

endmodule
